// File: rtl/switch_dest_tagger.sv
// switch_dest_tagger
// Learning MAC lookup stage in front of a switch fabric. Every ingress beat is
// registered once (1-cycle latency) and tagged with a one-hot/multi-hot egress
// mask (tdest). The mask is looked up from the destination MAC on the first
// beat of a frame and held for the rest of it. The source MAC, which spans the
// first two beats, is learned against the ingress port on the second beat.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   s_axis_* (tdata..tuser)      ingress frame stream, tid = ingress port
//   s_axis_tready                combinational: !m_axis_tvalid || m_axis_tready
//   m_axis_* (tdata..tuser)      registered egress stream, tdest = egress mask
//
// Optional feature
//   SWITCH_DEST_TAGGER_AGING_EN  when defined, entries not refreshed between
//                                two sweeps (every AGING_PERIOD cycles) expire.
module switch_dest_tagger #(
    parameter int unsigned AXIS_DATA_WIDTH = 64,
    parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int unsigned AXIS_ID_WIDTH   = 8,
    parameter int unsigned AXIS_USER_WIDTH = 17,
    parameter int unsigned RADIX           = 4,
    parameter int unsigned AXIS_DEST_WIDTH = RADIX,
    parameter int unsigned TABLE_SIZE      = 16,
    parameter int unsigned AGING_PERIOD    = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_ID_WIDTH-1:0]   s_axis_tid,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_ID_WIDTH-1:0]   m_axis_tid,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser
);

    localparam int unsigned MAC_W  = 48;
    localparam int unsigned PORT_W = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam int unsigned IDX_W  = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

    // Only the 64-bit beat layout is implemented; the MAC byte positions depend on it.
    if (AXIS_DATA_WIDTH != 64 || AXIS_KEEP_WIDTH != 8 || AGING_PERIOD == 0) begin : g_bad_params
        $error("switch_dest_tagger: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_FIRST, ST_SECOND, ST_BODY} state_t;

    state_t                     state, state_nxt;
    logic                       s_fire;
    logic                       port_ok;
    logic [PORT_W-1:0]          in_port;
    logic [MAC_W-1:0]           dst_mac, src_mac;
    logic [15:0]                src_lo;      // src MAC bytes 0..1, carried from beat 0
    logic [AXIS_DEST_WIDTH-1:0] frame_dest;  // mask held for the remaining beats
    logic [AXIS_DEST_WIDTH-1:0] first_dest;
    logic                       dst_hit, src_hit, learn_en;
    logic [PORT_W-1:0]          dst_port;
    logic [IDX_W-1:0]           src_idx;

    logic [TABLE_SIZE-1:0]      tbl_valid;
    logic [MAC_W-1:0]           tbl_mac  [TABLE_SIZE];
    logic [PORT_W-1:0]          tbl_port [TABLE_SIZE];
    logic [IDX_W-1:0]           rep_ptr;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign in_port       = s_axis_tid[PORT_W-1:0];
    assign port_ok       = 32'(s_axis_tid) < RADIX;
    assign dst_mac       = s_axis_tdata[47:0];
    assign src_mac       = {s_axis_tdata[31:0], src_lo};
    // Unicast test uses byte 0 bit 0 of the source MAC, captured with beat 0.
    assign learn_en      = s_fire && (state == ST_SECOND) && !src_lo[0] && port_ok;

    // Associative match of both MACs over valid entries (table contents before any write).
    always_comb begin
        dst_hit  = 1'b0;
        dst_port = '0;
        src_hit  = 1'b0;
        src_idx  = '0;
        for (int i = 0; i < int'(TABLE_SIZE); i++) begin
            if (tbl_valid[i] && tbl_mac[i] == dst_mac) begin
                dst_hit  = 1'b1;
                dst_port = tbl_port[i];
            end
            if (tbl_valid[i] && tbl_mac[i] == src_mac) begin
                src_hit = 1'b1;
                src_idx = IDX_W'(i);
            end
        end
    end

    // Egress mask for a frame's first beat: flood, forward, or filter back to the ingress port.
    always_comb begin
        first_dest = '1;
        if (port_ok) begin
            if (dst_mac[0] || !dst_hit) begin
                first_dest = ~(AXIS_DEST_WIDTH'(1) << in_port);
            end else if (dst_port == in_port) begin
                first_dest = '0;
            end else begin
                first_dest = AXIS_DEST_WIDTH'(1) << dst_port;
            end
        end
    end

    // Frame position state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame position next state.
    always_comb begin
        state_nxt = state;
        if (s_fire) begin
            if (s_axis_tlast) begin
                state_nxt = ST_FIRST;
            end else begin
                case (state)
                    ST_FIRST:  state_nxt = ST_SECOND;
                    default:   state_nxt = ST_BODY;
                endcase
            end
        end
    end

    // Single output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
            frame_dest    <= '0;
            src_lo        <= '0;
        end else if (s_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tid    <= s_axis_tid;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tdest  <= (state == ST_FIRST) ? first_dest : frame_dest;
            if (state == ST_FIRST) begin
                frame_dest <= first_dest;
                src_lo     <= s_axis_tdata[63:48];
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef SWITCH_DEST_TAGGER_AGING_EN
    localparam int unsigned AGE_W = (AGING_PERIOD > 1) ? $clog2(AGING_PERIOD) : 1;

    logic [TABLE_SIZE-1:0] tbl_age;
    logic [AGE_W-1:0]      age_cnt;
    logic                  age_sweep;

    assign age_sweep = (age_cnt == AGE_W'(AGING_PERIOD - 1));
`endif

    // MAC table: learning, replacement pointer and (optionally) aging sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid <= '0;
            rep_ptr   <= '0;
            for (int i = 0; i < int'(TABLE_SIZE); i++) begin
                tbl_mac[i]  <= '0;
                tbl_port[i] <= '0;
            end
`ifdef SWITCH_DEST_TAGGER_AGING_EN
            tbl_age <= '0;
            age_cnt <= '0;
`endif
        end else begin
`ifdef SWITCH_DEST_TAGGER_AGING_EN
            // Sweep first so a learn in the same cycle overrides it for its entry.
            age_cnt <= age_sweep ? '0 : age_cnt + AGE_W'(1);
            if (age_sweep) begin
                tbl_valid <= tbl_valid & tbl_age;
                tbl_age   <= '0;
            end
`endif
            if (learn_en) begin
                if (src_hit) begin
                    tbl_valid[src_idx] <= 1'b1;
                    tbl_port[src_idx]  <= in_port;
`ifdef SWITCH_DEST_TAGGER_AGING_EN
                    tbl_age[src_idx]   <= 1'b1;
`endif
                end else begin
                    tbl_valid[rep_ptr] <= 1'b1;
                    tbl_mac[rep_ptr]   <= src_mac;
                    tbl_port[rep_ptr]  <= in_port;
                    rep_ptr            <= rep_ptr + IDX_W'(1);
`ifdef SWITCH_DEST_TAGGER_AGING_EN
                    tbl_age[rep_ptr]   <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_dest_tagger.sv
// Self-checking bench for switch_dest_tagger: scoreboarded random and directed
// frames against a MAC-table model built from associative arrays.
`timescale 1ns/1ps
module tb_switch_dest_tagger;

    localparam int unsigned RADIX = 4;
    localparam int unsigned TS    = 16;
    localparam int unsigned AP    = 100;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [16:0] user;
        logic [3:0]  dest;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tid = '0;
    logic [16:0] s_axis_tuser = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [3:0]  m_axis_tdest;
    logic [16:0] m_axis_tuser;

    switch_dest_tagger #(.AGING_PERIOD(AP)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int valid_pct = 100;
    int ready_pct = 100;
    int acc_cnt = 0;

    beat_t      in_q[$];
    beat_t      exp_q[$];
    logic [3:0] obs_q[$];

    // Reference MAC table: valid entries as mac->port, slot bookkeeping for FIFO replacement.
    int         lut[bit [47:0]];
    int         slot_of[bit [47:0]];
    bit [47:0]  slot_mac[TS];
    bit         slot_used[TS];
    int         ptr;
    int         fidx;
    logic [3:0] fdest;
    logic [15:0] src_lo;
`ifdef SWITCH_DEST_TAGGER_AGING_EN
    bit         aged[bit [47:0]];
    int         cyc;
`endif

    function automatic bit [47:0] mk_mac(input logic [7:0] tag);
        return {tag, 32'h0, 8'h02};
    endfunction

    function automatic logic [3:0] calc_dest(input bit [47:0] mac, input logic [7:0] id);
        int p, q;
        if (id >= RADIX) return 4'hF;
        p = int'(id);
        if (mac[0] || !lut.exists(mac)) return 4'hF & ~(4'h1 << p);
        q = lut[mac];
        return (q == p) ? 4'h0 : 4'(4'h1 << q);
    endfunction

    task automatic model_learn(input bit [47:0] mac, input int port);
        bit [47:0] old;
        if (lut.exists(mac)) begin
            lut[mac] = port;
        end else begin
            if (slot_used[ptr]) begin
                old = slot_mac[ptr];
                if (lut.exists(old) && slot_of[old] == ptr) lut.delete(old);
            end
            slot_mac[ptr]  = mac;
            slot_used[ptr] = 1'b1;
            lut[mac]       = port;
            slot_of[mac]   = ptr;
            ptr            = (ptr + 1) % TS;
        end
`ifdef SWITCH_DEST_TAGGER_AGING_EN
        aged[mac] = 1'b1;
`endif
    endtask

`ifdef SWITCH_DEST_TAGGER_AGING_EN
    task automatic model_sweep();
        bit [47:0] keys[$];
        foreach (lut[k]) keys.push_back(k);
        foreach (keys[i]) if (!aged.exists(keys[i])) lut.delete(keys[i]);
        aged.delete();
    endtask
`endif

    task automatic model_reset();
        lut.delete();
        slot_of.delete();
        foreach (slot_used[i]) slot_used[i] = 1'b0;
        ptr  = 0;
        fidx = 0;
        exp_q.delete();
`ifdef SWITCH_DEST_TAGGER_AGING_EN
        aged.delete();
        cyc = 0;
`endif
    endtask

    task automatic add_frame(input bit [47:0] dst, input bit [47:0] src,
                             input logic [7:0] tid, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {$urandom, $urandom};
            if (i == 0) b.data = {src[15:0], dst};
            if (i == 1) b.data[31:0] = src[47:16];
            b.last = (i == nbeats - 1);
            b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.id   = tid;
            b.user = 17'($urandom);
            b.dest = '0;
            in_q.push_back(b);
        end
    endtask

    // One clock: drive from the negedge, check and update the model just before the posedge.
    task automatic tick_body();
        beat_t b, obs, exp_b;
        bit s_fire, m_fire, do_learn;
        bit [47:0] lmac;
        int lport;
        if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            b = in_q[0];
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b.data;
            s_axis_tkeep  = b.keep;
            s_axis_tlast  = b.last;
            s_axis_tid    = b.id;
            s_axis_tuser  = b.user;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = {$urandom, $urandom};
        end
        m_axis_tready = ($urandom_range(99) < ready_pct);
        #1;
        total++;
        if (s_axis_tready !== (exp_q.size() == 0 || m_axis_tready)) begin
            bad++;
            $display("FAIL tready got=%b exp=%b", s_axis_tready, (exp_q.size() == 0 || m_axis_tready));
        end
        total++;
        if (m_axis_tvalid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL tvalid got=%b exp=%b", m_axis_tvalid, (exp_q.size() != 0));
        end
        m_fire = m_axis_tvalid && m_axis_tready;
        if (m_fire) begin
            obs = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser, m_axis_tdest};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat got=%h exp=none", obs);
            end else begin
                exp_b = exp_q.pop_front();
                if (obs !== exp_b) begin
                    bad++;
                    $display("FAIL beat got=%h exp=%h (dest got=%b exp=%b)", obs, exp_b, obs.dest, exp_b.dest);
                end
            end
            obs_q.push_back(m_axis_tdest);
        end
        s_fire   = s_axis_tvalid && s_axis_tready;
        do_learn = 1'b0;
        lmac     = '0;
        lport    = 0;
        if (s_fire) begin
            b = in_q.pop_front();
            acc_cnt++;
            if (fidx == 0) begin
                fdest  = calc_dest(b.data[47:0], b.id);
                src_lo = b.data[63:48];
            end
            if (fidx == 1 && !src_lo[0] && b.id < RADIX) begin
                do_learn = 1'b1;
                lmac     = {b.data[31:0], src_lo};
                lport    = int'(b.id);
            end
            exp_b      = b;
            exp_b.dest = fdest;
            exp_q.push_back(exp_b);
            fidx = b.last ? 0 : fidx + 1;
        end
`ifdef SWITCH_DEST_TAGGER_AGING_EN
        cyc++;
        if (cyc % AP == 0) model_sweep();
`endif
        if (do_learn) model_learn(lmac, lport);
        @(posedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        tick_body();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (in_q.size() > 0 || exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d pending exp=0/0", in_q.size(), exp_q.size());
        end
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid);
        end
        total++;
        if (m_axis_tdata !== 64'h0 || m_axis_tdest !== 4'h0 || m_axis_tlast !== 1'b0 ||
            m_axis_tid !== 8'h0 || m_axis_tuser !== 17'h0 || m_axis_tkeep !== 8'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b exp=0/0", m_axis_tdata, m_axis_tdest);
        end
        model_reset();
        in_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick_body();
    endtask

    task automatic check_dest(input string name, input int idx, input logic [3:0] exp);
        total++;
        if (idx >= obs_q.size()) begin
            bad++;
            $display("FAIL %s missing beat %0d got=none exp=%b", name, idx, exp);
        end else if (obs_q[idx] !== exp) begin
            bad++;
            $display("FAIL %s beat %0d got=%b exp=%b", name, idx, obs_q[idx], exp);
        end
    endtask

    task automatic test_reset();
        valid_pct = 100;
        ready_pct = 100;
        apply_reset();
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready got=%b exp=1", s_axis_tready);
        end
    endtask

    task automatic test_flood();
        apply_reset();
        obs_q.delete();
        add_frame(mk_mac(8'hAA), mk_mac(8'h11), 8'd1, 3);
        drain(100);
        for (int i = 0; i < 3; i++) check_dest("flood", i, 4'b1101);
    endtask

    task automatic test_learn();
        apply_reset();
        obs_q.delete();
        add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'hBB), 8'd2, 2);
        add_frame(mk_mac(8'hBB), mk_mac(8'h21), 8'd0, 3);
        add_frame(mk_mac(8'hBB), mk_mac(8'h22), 8'd2, 2);
        add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'h23), 8'd3, 1);
        drain(200);
        check_dest("bcast_learn", 0, 4'b1011);
        for (int i = 2; i < 5; i++) check_dest("fwd_hit", i, 4'b0100);
        for (int i = 5; i < 7; i++) check_dest("filtered", i, 4'b0000);
        check_dest("bcast", 7, 4'b0111);
    endtask

    task automatic test_evict();
        apply_reset();
        ready_pct = 50;
        obs_q.delete();
        for (int i = 0; i < 17; i++) add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'(8'h40 + i)), 8'd1, 2);
        add_frame(mk_mac(8'h40), mk_mac(8'h01), 8'd0, 1);
        add_frame(mk_mac(8'h50), mk_mac(8'h01), 8'd0, 1);
        drain(400);
        check_dest("evicted_miss", 34, 4'b1110);
        check_dest("newest_hit", 35, 4'b0010);
        ready_pct = 100;
    endtask

    task automatic test_aging();
        apply_reset();
        obs_q.delete();
        add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'hBB), 8'd2, 2);
        drain(50);
        for (int i = 0; i < 250; i++) tick();
        add_frame(mk_mac(8'hBB), mk_mac(8'h31), 8'd0, 1);
        drain(50);
`ifdef SWITCH_DEST_TAGGER_AGING_EN
        check_dest("aged_out", 2, 4'b1110);
`else
        check_dest("no_aging", 2, 4'b0100);
`endif
    endtask

    task automatic test_reset_mid();
        int target, n;
        apply_reset();
        add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'hCC), 8'd3, 2);
        drain(50);
        add_frame(48'hFFFF_FFFF_FFFF, mk_mac(8'h41), 8'd0, 5);
        target = acc_cnt + 3;
        n = 0;
        while (acc_cnt < target && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (acc_cnt < target) begin
            bad++;
            $display("FAIL mid_frame_wait got=%0d exp=%0d", acc_cnt, target);
        end
        apply_reset();
        obs_q.delete();
        add_frame(mk_mac(8'hCC), mk_mac(8'h42), 8'd1, 2);
        drain(50);
        check_dest("post_reset_first", 0, 4'b1101);
        check_dest("post_reset_held", 1, 4'b1101);
    endtask

    task automatic test_random();
        bit [47:0] dst, src;
        int r;
        apply_reset();
        valid_pct = 70;
        ready_pct = 60;
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(99);
            if (r < 10)      dst = 48'hFFFF_FFFF_FFFF;
            else if (r < 15) dst = {8'($urandom_range(23)), 32'h0, 8'h03};
            else             dst = mk_mac(8'($urandom_range(23)));
            if ($urandom_range(9) == 0) src = {8'($urandom_range(23)), 32'h0, 8'h01};
            else                        src = mk_mac(8'($urandom_range(23)));
            add_frame(dst, src, 8'($urandom_range(4)), $urandom_range(1, 5));
        end
        drain(5000);
        valid_pct = 100;
        ready_pct = 100;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_flood();
        test_learn();
        test_evict();
        test_aging();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
